axis_shutdown_ctrl: RTL and testbench
=====================================

// Module: axis_shutdown_ctrl
// PURPOSE
//  Initiator side of the AXIS shutdown handshake: drives shutdown_req to C_NUM_PORTS stream gates and collects
//  their shutdown_ack. Turns one run/stop control bit into a sequenced stop, then resume, with aggregate status.
//  Sits between the control register file and the per-interface shutdown gates; all on one clock domain.
// PARAMETERS
//  C_NUM_PORTS       4     number of gate req/ack pairs (1..32)
//  C_TIMEOUT_CYCLES  4096  cycles allowed per DRAIN/RESUME wait (used only with the timeout macro; >=2)
//  C_RESET_STOPPED   0     1: leave reset in DRAIN (req asserted on all ports); 0: leave reset in RUN
// PORTS
//  clk             in   1            clock
//  rst             in   1            synchronous reset, active-high
//  enable          in   1            1 = streams run, 0 = streams stopped
//  port_mask       in   C_NUM_PORTS  1 = port participates; latched on RUN->DRAIN and HALTED->RESUME
//  shutdown_req    out  C_NUM_PORTS  to gates; registered
//  shutdown_ack    in   C_NUM_PORTS  from gates
//  running         out  1            state == RUN
//  stopped         out  1            state == HALTED
//  busy            out  1            state is DRAIN or RESUME
//  timeout_err     out  1            sticky timeout flag (0 when macro off)
//  timeout_ports   out  C_NUM_PORTS  active ports that missed the wait at timeout (0 when macro off)
// BEHAVIOUR
//  Reset: state=RUN (DRAIN if C_RESET_STOPPED), mask_q=all ones, shutdown_req=0 (=all ones if C_RESET_STOPPED),
//   running=1/stopped=0/busy=0 (busy=1 if C_RESET_STOPPED), timeout_err=0, timeout_ports=0, counter=0.
//   Reset mid-operation drops req to reset value the next cycle; gates resume/stop on their own packet boundary.
//  all_ack = &(shutdown_ack | ~mask_q); none_ack = ~|(shutdown_ack & mask_q).
//  FSM (registered; outputs derive from registered state/req only):
//   RUN:    enable==0 -> DRAIN; mask_q<=port_mask; shutdown_req<=port_mask; counter<=0.
//   DRAIN:  all_ack -> HALTED. enable==1 before all_ack -> RESUME (abort), shutdown_req<=0, counter<=0.
//   HALTED: enable==1 -> RESUME; mask_q<=port_mask; shutdown_req<=0; counter<=0.
//   RESUME: none_ack -> RUN. enable==0 before none_ack -> DRAIN, shutdown_req<=mask_q, counter<=0.
//  all_ack and enable both valid in DRAIN: all_ack wins (HALTED); HALTED->RESUME on the following cycle.
//   Same rule in RESUME: none_ack wins.
//  Latency: enable falls in cycle T -> req high in T+1; a gate acks at T+3 with idle input (+ packet tail);
//   HALTED from the cycle after all_ack is sampled.
//  Masked-off ports never see req asserted; their ack is ignored. mask_q==0: DRAIN->HALTED in 1 cycle.
//  Ports whose ack drops during HALTED are not monitored (no state change).
// CONFIGURATION
//  AXIS_SHUTDOWN_CTRL_TIMEOUT_EN defined:
//   - $clog2(C_TIMEOUT_CYCLES)-bit counter increments each DRAIN/RESUME cycle, saturating; cleared on entry.
//   - At counter==C_TIMEOUT_CYCLES-1 with the wait unmet: timeout_err<=1.
//     DRAIN: timeout_ports<=mask_q & ~shutdown_ack, forced HALTED (req stays high).
//     RESUME: timeout_ports<=mask_q & shutdown_ack, forced RUN.
//   - timeout_err/timeout_ports clear only on reset or the next RUN->DRAIN transition.
//  Not defined: no counter; waits are unbounded; timeout_err and timeout_ports tied 0.
// TESTING
//  1 N=4, mask=4'hF, gates idle, enable 1->0 -> req=4'hF next cycle; stopped=1 after all four acks; busy high between.
//  2 Gate 2 mid-packet (10 beats left) -> HALTED only after gate 2 tlast accepted; other acks ignored until then.
//  3 HALTED, enable 0->1 -> req=0 next cycle; running=1 the cycle after all acks low; no beats lost or duplicated.
//  4 enable 1->0 then 1 two cycles later (DRAIN abort) -> RESUME, req=0, RUN once acks low; no truncated packet.
//  5 mask=4'b0101 -> req=4'b0101 only; ack[1],ack[3] forced high/low -> no effect on FSM.
//  6 TIMEOUT_EN, C_TIMEOUT_CYCLES=16, gate 3 never acks -> HALTED 16 cycles after DRAIN entry,
//    timeout_err=1, timeout_ports=4'b1000; cleared on the next stop.

Source files
------------

// File: rtl/axis_shutdown_ctrl_if.sv
// Shutdown request/acknowledge bundle between the controller and its stream gates.
interface axis_shutdown_ctrl_if #(
    parameter int C_NUM_PORTS = 4
);
    logic [C_NUM_PORTS-1:0] shutdown_req;
    logic [C_NUM_PORTS-1:0] shutdown_ack;

    modport master (output shutdown_req, input shutdown_ack);
    modport slave  (input shutdown_req, output shutdown_ack);
endinterface

// File: rtl/axis_shutdown_ctrl.sv
// Sequences stop/resume of C_NUM_PORTS AXIS gates from a single enable bit.
// Optional wait timeout: define AXIS_SHUTDOWN_CTRL_TIMEOUT_EN.
module axis_shutdown_ctrl #(
    parameter int C_NUM_PORTS      = 4,
    parameter int C_TIMEOUT_CYCLES = 4096,
    parameter int C_RESET_STOPPED  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [C_NUM_PORTS-1:0] port_mask,
    axis_shutdown_ctrl_if.master   gates,
    output logic                   running,
    output logic                   stopped,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [C_NUM_PORTS-1:0] timeout_ports
);
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2,
        S_RESUME = 2'd3
    } state_t;

    localparam state_t RST_STATE = (C_RESET_STOPPED != 0) ? S_DRAIN : S_RUN;
    localparam logic [C_NUM_PORTS-1:0] RST_REQ = (C_RESET_STOPPED != 0) ? {C_NUM_PORTS{1'b1}}
                                                                         : {C_NUM_PORTS{1'b0}};

    if (C_NUM_PORTS < 1 || C_NUM_PORTS > 32 || C_TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("axis_shutdown_ctrl: parameter out of range");
    end

    state_t                 state_q, state_d;
    logic [C_NUM_PORTS-1:0] req_q, req_d;
    logic [C_NUM_PORTS-1:0] mask_q, mask_d;
    logic [C_NUM_PORTS-1:0] ack;
    logic                   all_ack, none_ack;
    logic                   waiting;
    logic                   tmo;

    assign ack                = gates.shutdown_ack;
    assign gates.shutdown_req = req_q;

    // Masked-off ports count as acked for stop and as released for resume.
    assign all_ack  = &(ack | ~mask_q);
    assign none_ack = ~|(ack & mask_q);
    assign waiting  = (state_q == S_DRAIN) || (state_q == S_RESUME);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            req_q   <= RST_REQ;
            mask_q  <= {C_NUM_PORTS{1'b1}};
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            mask_q  <= mask_d;
        end
    end

    // Completion of the wait outranks both the timeout and a change of enable.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        mask_d  = mask_q;
        case (state_q)
            S_RUN: begin
                if (!enable) begin
                    state_d = S_DRAIN;
                    mask_d  = port_mask;
                    req_d   = port_mask;
                end
            end
            S_DRAIN: begin
                if (all_ack || tmo) begin
                    state_d = S_HALTED;
                end else if (enable) begin
                    state_d = S_RESUME;
                    req_d   = '0;
                end
            end
            S_HALTED: begin
                if (enable) begin
                    state_d = S_RESUME;
                    mask_d  = port_mask;
                    req_d   = '0;
                end
            end
            S_RESUME: begin
                if (none_ack || tmo) begin
                    state_d = S_RUN;
                end else if (!enable) begin
                    state_d = S_DRAIN;
                    req_d   = mask_q;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_comb begin
        running = (state_q == S_RUN);
        stopped = (state_q == S_HALTED);
        busy    = waiting;
    end

`ifdef AXIS_SHUTDOWN_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(C_TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(C_TIMEOUT_CYCLES - 1);

    logic [CW-1:0]          cnt_q;
    logic                   enter_wait;
    logic                   wait_met;
    logic                   err_q;
    logic [C_NUM_PORTS-1:0] tports_q;

    assign enter_wait = (state_d != state_q) && ((state_d == S_DRAIN) || (state_d == S_RESUME));
    assign wait_met   = (state_q == S_DRAIN) ? all_ack : none_ack;
    assign tmo        = waiting && (cnt_q == CNT_MAX) && !wait_met;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            err_q    <= 1'b0;
            tports_q <= '0;
        end else begin
            if (enter_wait)
                cnt_q <= '0;
            else if (waiting && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CW'(1);
            // Status from the previous stop survives until a new stop is requested.
            if (state_q == S_RUN && !enable) begin
                err_q    <= 1'b0;
                tports_q <= '0;
            end else if (tmo) begin
                err_q    <= 1'b1;
                tports_q <= (state_q == S_DRAIN) ? (mask_q & ~ack) : (mask_q & ack);
            end
        end
    end

    assign timeout_err   = err_q;
    assign timeout_ports = tports_q;
`else
    assign tmo           = 1'b0;
    assign timeout_err   = 1'b0;
    assign timeout_ports = '0;
`endif
endmodule

// File: tb/tb_axis_shutdown_ctrl.sv
// Directed + randomized bench for axis_shutdown_ctrl with a per-cycle reference model and gate models.
module tb_axis_shutdown_ctrl;
    localparam int N   = 4;
    localparam int TMO = 16;
`ifdef AXIS_SHUTDOWN_CTRL_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif
    localparam int P_RUN = 0, P_DRAIN = 1, P_HALT = 2, P_RES = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b1;
    logic [N-1:0] port_mask = '1;
    logic [N-1:0] ack_drv = '0;
    logic         running, stopped, busy, timeout_err;
    logic [N-1:0] timeout_ports;

    axis_shutdown_ctrl_if #(.C_NUM_PORTS(N)) sif ();
    assign sif.shutdown_ack = ack_drv;

    axis_shutdown_ctrl #(
        .C_NUM_PORTS(N), .C_TIMEOUT_CYCLES(TMO), .C_RESET_STOPPED(0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .port_mask(port_mask), .gates(sif.master),
        .running(running), .stopped(stopped), .busy(busy),
        .timeout_err(timeout_err), .timeout_ports(timeout_ports)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference: phase of the handshake, latched mask, request, wait age, timeout status.
    int           m_st = P_RUN;
    logic [N-1:0] m_mask = '1, m_req = '0, m_tp = '0;
    logic         m_err = 1'b0;
    int           m_wait = 0;

    // Gate models: each port follows its request after a random delay, unless forced.
    int           g_dly [N];
    int           g_maxd = 3;
    logic [N-1:0] f_en = '0, f_val = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic a, n;
        a = &(ack_drv | ~m_mask);
        n = ~|(ack_drv & m_mask);
        if (rst) begin
            m_st = P_RUN; m_mask = '1; m_req = '0; m_err = 1'b0; m_tp = '0; m_wait = 0;
            return;
        end
        case (m_st)
            P_RUN: if (!enable) begin
                m_st = P_DRAIN; m_mask = port_mask; m_req = port_mask; m_wait = 0;
                m_err = 1'b0; m_tp = '0;
            end
            P_DRAIN: begin
                if (a) m_st = P_HALT;
                else if (TMO_ON && m_wait == TMO - 1) begin
                    m_st = P_HALT; m_err = 1'b1; m_tp = m_mask & ~ack_drv;
                end else if (enable) begin
                    m_st = P_RES; m_req = '0; m_wait = 0;
                end else if (m_wait < TMO - 1) m_wait++;
            end
            P_HALT: if (enable) begin
                m_st = P_RES; m_mask = port_mask; m_req = '0; m_wait = 0;
            end
            default: begin
                if (n) m_st = P_RUN;
                else if (TMO_ON && m_wait == TMO - 1) begin
                    m_st = P_RUN; m_err = 1'b1; m_tp = m_mask & ack_drv;
                end else if (!enable) begin
                    m_st = P_DRAIN; m_req = m_mask; m_wait = 0;
                end else if (m_wait < TMO - 1) m_wait++;
            end
        endcase
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("req", 32'(sif.shutdown_req), 32'(m_req));
        chk("running", 32'(running), 32'(m_st == P_RUN));
        chk("stopped", 32'(stopped), 32'(m_st == P_HALT));
        chk("busy", 32'(busy), 32'(m_st == P_DRAIN || m_st == P_RES));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        chk("timeout_ports", 32'(timeout_ports), 32'(m_tp));
        for (int i = 0; i < N; i++) begin
            if (f_en[i]) ack_drv[i] = f_val[i];
            else if (ack_drv[i] != m_req[i]) begin
                if (g_dly[i] == 0) begin
                    ack_drv[i] = m_req[i];
                    g_dly[i] = $urandom_range(0, g_maxd);
                end else g_dly[i]--;
            end
        end
    endtask

    // Steps until the DUT status reports the wanted phase; an expired budget is a failure.
    task automatic run_until(input int st, input int budget, input string tag);
        logic [2:0] want;
        want = (st == P_RUN) ? 3'b001 : (st == P_HALT) ? 3'b010 : 3'b100;
        for (int k = 0; k < budget && m_st != st; k++) step();
        chk(tag, 32'({busy, stopped, running}), 32'(want));
    endtask

    initial begin
        for (int i = 0; i < N; i++) g_dly[i] = 0;
        rst = 1'b1;
        step();
        step();
        chk("reset_req", 32'(sif.shutdown_req), 32'h0);
        chk("reset_status", 32'({busy, stopped, running}), 32'b001);
        rst = 1'b0;
        step();

        // Full stop with idle gates, then one gate holding a long packet tail.
        g_dly[2] = 10;
        enable = 1'b0;
        step();
        chk("stop_req_next_cycle", 32'(sif.shutdown_req), 32'hF);
        run_until(P_HALT, 40, "stop_reached");
        enable = 1'b1;
        step();
        chk("resume_req_next_cycle", 32'(sif.shutdown_req), 32'h0);
        run_until(P_RUN, 40, "resume_reached");

        // Abort a stop two cycles in.
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        run_until(P_RUN, 40, "abort_back_to_run");

        // Partial mask with unmasked ports' acks forced against the request.
        port_mask = 4'b0101;
        f_en = 4'b1010;
        f_val = 4'b0010;
        enable = 1'b0;
        step();
        chk("mask_req", 32'(sif.shutdown_req), 32'h5);
        run_until(P_HALT, 40, "masked_stop");
        enable = 1'b1;
        run_until(P_RUN, 40, "masked_resume");
        f_en = '0;
        step();
        step();

        // Empty mask: halted straight after the single DRAIN cycle.
        port_mask = '0;
        enable = 1'b0;
        step();
        step();
        chk("empty_mask_halt", 32'({busy, stopped}), 32'b01);
        enable = 1'b1;
        run_until(P_RUN, 20, "empty_mask_resume");

        // Port 3 never acknowledges.
        port_mask = '1;
        f_en = 4'b1000;
        f_val = 4'b0000;
        enable = 1'b0;
        for (int k = 0; k < TMO + 4; k++) step();
        chk("stuck_err", 32'(timeout_err), 32'(TMO_ON));
        chk("stuck_ports", 32'(timeout_ports), TMO_ON ? 32'h8 : 32'h0);
        enable = 1'b1;
        run_until(P_RUN, 40, "stuck_resume");
        f_en = '0;
        enable = 1'b0;
        step();
        chk("err_cleared_on_stop", 32'(timeout_err), 32'h0);
        run_until(P_HALT, 40, "restop_reached");
        enable = 1'b1;
        run_until(P_RUN, 40, "restart_reached");

        // Randomized enable, mask, gate latency and occasional reset.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            if ($urandom_range(0, 9) == 0) port_mask = N'($urandom);
            if ($urandom_range(0, 19) == 0) g_maxd = $urandom_range(0, 6);
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
